// File: rtl/huffman_encoder.sv
// Serialising unary-canonical Huffman encoder: one 5-bit symbol in, its prefix code out MSB-first.
// Optional statistics counters (sym_count, bit_count) are enabled by defining HUFF_ENC_STATS_EN.
module huffman_encoder #(
  parameter int NUM_SYM = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] sym_in,
  input  logic       sym_valid,
  output logic       sym_ready,
  output logic       bit_out,
  output logic       bit_valid,
  input  logic       bit_ready,
  output logic       bit_last,
  output logic       err_out
`ifdef HUFF_ENC_STATS_EN
  ,
  output logic [15:0] sym_count,
  output logic [23:0] bit_count
`endif
);

  localparam int MAX_LEN = NUM_SYM - 1;
  localparam int CW      = $clog2(MAX_LEN + 1);

  localparam logic [4:0]         NUM_SYM5 = 5'(NUM_SYM);
  localparam logic [MAX_LEN-1:0] ONES     = '1;
  localparam logic [CW-1:0]      ONE_C    = CW'(1);
  localparam logic [CW-1:0]      LEN_MAX  = CW'(MAX_LEN);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t             state, state_n;
  logic [MAX_LEN-1:0] shift_q, shift_n, code;
  logic [CW-1:0]      cnt_q, cnt_n, len;
  logic               last_n, err_n, legal, accept;

  assign legal     = (sym_in != 5'd0) && (sym_in <= NUM_SYM5);
  assign sym_ready = (state == IDLE) || ((state == SHIFT) && bit_ready && bit_last);
  assign accept    = sym_valid && sym_ready;

  // Left-aligned code: k-1 leading ones; for k == NUM_SYM the shift clears all bits, giving all ones.
  assign code = ~(ONES >> (sym_in - 5'd1));
  assign len  = (sym_in == NUM_SYM5) ? LEN_MAX : CW'(sym_in);

  assign bit_valid = (state == SHIFT);
  assign bit_out   = shift_q[MAX_LEN-1];

  always_comb begin
    state_n = state;
    shift_n = shift_q;
    cnt_n   = cnt_q;
    err_n   = 1'b0;
    if ((state == SHIFT) && bit_ready) begin
      shift_n = shift_q << 1;
      cnt_n   = cnt_q - ONE_C;
      if (bit_last) state_n = IDLE;
    end
    if (accept) begin
      if (legal) begin
        shift_n = code;
        cnt_n   = len;
        state_n = SHIFT;
      end else begin
        err_n = 1'b1;
      end
    end
    last_n = (state_n == SHIFT) && (cnt_n == ONE_C);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      shift_q  <= '0;
      cnt_q    <= '0;
      bit_last <= 1'b0;
      err_out  <= 1'b0;
    end else begin
      state    <= state_n;
      shift_q  <= shift_n;
      cnt_q    <= cnt_n;
      bit_last <= last_n;
      err_out  <= err_n;
    end
  end

`ifdef HUFF_ENC_STATS_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sym_count <= '0;
      bit_count <= '0;
    end else begin
      if (accept && legal && (sym_count != '1)) sym_count <= sym_count + 16'd1;
      if (bit_valid && bit_ready && (bit_count != '1)) bit_count <= bit_count + 24'd1;
    end
  end
`endif

endmodule

// File: tb/tb_huffman_encoder.sv
// Scoreboard bench for huffman_encoder: stimulus pushes hand-written codes, a negedge monitor pops and compares.
module tb_huffman_encoder;

  localparam int NUM_SYM = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [4:0] sym_in = '0;
  logic       sym_valid = 1'b0;
  logic       sym_ready;
  logic       bit_out;
  logic       bit_valid;
  logic       bit_ready = 1'b1;
  logic       bit_last;
  logic       err_out;
`ifdef HUFF_ENC_STATS_EN
  logic [15:0] sym_count;
  logic [23:0] bit_count;
`endif

  huffman_encoder #(.NUM_SYM(NUM_SYM)) dut (
    .clk       (clk),
    .rst       (rst),
    .sym_in    (sym_in),
    .sym_valid (sym_valid),
    .sym_ready (sym_ready),
    .bit_out   (bit_out),
    .bit_valid (bit_valid),
    .bit_ready (bit_ready),
    .bit_last  (bit_last),
    .err_out   (err_out)
`ifdef HUFF_ENC_STATS_EN
    ,
    .sym_count (sym_count),
    .bit_count (bit_count)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc++;

  logic [1:0] exp_q[$];
  int         err_q[$];
  int         last_xfer_cyc = 0;
  int         err_seen = 0;
  logic       prev_hold = 1'b0;
  logic       prev_bit = 1'b0;
  logic       prev_last = 1'b0;
  logic [1:0] e;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Hand-written code table for the symbols exercised (NUM_SYM = 8).
  function automatic string code_of(input int k);
    case (k)
      1:       return "0";
      2:       return "10";
      3:       return "110";
      4:       return "1110";
      8:       return "1111111";
      default: return "";
    endcase
  endfunction

  always @(negedge clk) begin
    if (rst) begin
      if (prev_hold) begin
        chk("hold_valid", int'(bit_valid), 1);
        chk("hold_bit", int'(bit_out), int'(prev_bit));
        chk("hold_last", int'(bit_last), int'(prev_last));
      end
      if (bit_valid && bit_ready) begin
        if (exp_q.size() == 0) chk("unexpected_bit", 1, 0);
        else begin
          e = exp_q.pop_front();
          chk("bit_out", int'(bit_out), int'(e[1]));
          chk("bit_last", int'(bit_last), int'(e[0]));
        end
        last_xfer_cyc = cyc;
      end
      if (err_out) begin
        err_seen++;
        if (err_q.size() == 0) chk("unexpected_err", 1, 0);
        else chk("err_cycle", cyc, err_q.pop_front());
      end
      prev_hold = bit_valid && !bit_ready;
      prev_bit  = bit_out;
      prev_last = bit_last;
    end else begin
      prev_hold = 1'b0;
    end
  end

  task automatic send(input int k, output int acc_cyc);
    bit    got;
    int    n;
    string s;
    got = 1'b0;
    n = 0;
    sym_in = 5'(k);
    sym_valid = 1'b1;
    while (!got && n < 50) begin
      @(negedge clk);
      got = sym_ready;
      @(posedge clk);
      #1;
      n++;
    end
    if (!got) chk("accept_timeout", 0, 1);
    acc_cyc = cyc;
    sym_valid = 1'b0;
    if (k >= 1 && k <= NUM_SYM) begin
      s = code_of(k);
      for (int i = 0; i < s.len(); i++)
        exp_q.push_back({s[i] == "1", i == s.len() - 1});
    end else begin
      err_q.push_back(cyc);
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || bit_valid) && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 100) chk("idle_timeout", 0, 1);
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_bit_valid"}, int'(bit_valid), 0);
    chk({tag, "_bit_out"}, int'(bit_out), 0);
    chk({tag, "_bit_last"}, int'(bit_last), 0);
    chk({tag, "_err_out"}, int'(err_out), 0);
    chk({tag, "_sym_ready"}, int'(sym_ready), 1);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    int a, a3, es0;

    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst = 1'b1;
    @(posedge clk);
    #1;

    // 1: single-bit code
    send(1, a);
    wait_idle();
    chk("t1_sym_ready", int'(sym_ready), 1);
    chk("t1_bit_valid", int'(bit_valid), 0);
    chk("t1_span", last_xfer_cyc - a, 0);

    // 2: back-to-back 3 then 2, no idle bit cycle
    send(3, a3);
    send(2, a);
    wait_idle();
    chk("t2_span", last_xfer_cyc - a3, 4);

    // 3: longest code with toggling backpressure
    send(8, a);
    for (int n = 0; n < 40 && exp_q.size() != 0; n++) begin
      @(posedge clk);
      #1;
      bit_ready = ~bit_ready;
    end
    bit_ready = 1'b1;
    wait_idle();
    chk("t3_span", last_xfer_cyc - a, 12);

    // 4: illegal symbols 0 and 9
    es0 = err_seen;
    send(0, a);
    send(9, a);
    wait_idle();
    chk("t4_err_count", err_seen - es0, 2);
    chk("t4_err_q_empty", err_q.size(), 0);

    // 5: reset during bit 2 of symbol 4
    send(4, a);
    @(posedge clk);
    #1;
    chk("t5_mid_valid", int'(bit_valid), 1);
    rst = 1'b0;
    #1;
    check_reset_outputs("t5_rst");
    exp_q.delete();
    @(posedge clk);
    #1;
    rst = 1'b1;
    send(2, a);
    wait_idle();

    // 6: fresh reset, then 1,2,3,0
    rst = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    es0 = err_seen;
    send(1, a);
    send(2, a);
    send(3, a);
    send(0, a);
    wait_idle();
    chk("t6_err_count", err_seen - es0, 1);
`ifdef HUFF_ENC_STATS_EN
    chk("t6_sym_count", int'(sym_count), 3);
    chk("t6_bit_count", int'(bit_count), 6);
`endif

    chk("exp_q_empty", exp_q.size(), 0);
    chk("err_q_empty", err_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
